// File: rtl/ahb_gpio_master_arb_if.sv
// AHB-lite bus between the two-requester GPIO front end and the GPIO slave.
// It also carries the parity-mode select and the parity-error return.
interface ahb_gpio_master_arb_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        PARITYSEL;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        PARITYERR;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY, PARITYSEL,
        input  HREADYOUT, HRDATA, PARITYERR
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY, PARITYSEL,
        output HREADYOUT, HRDATA, PARITYERR
    );
endinterface

// File: rtl/ahb_gpio_master_arb.sv
// Round-robin front end that shares one AHB-lite GPIO slave between two requesters.
// Each grant becomes one NONSEQ transfer, and its result goes back to the winner.
//
// state | meaning
// IDLE  | wait for a request, grant round-robin, latch it
// ADDR  | address phase, one cycle, NONSEQ
// DATA  | data phase, wait for HREADYOUT or the timeout
// RESP  | one-cycle response strobe to the granted requester
module ahb_gpio_master_arb #(
    parameter logic [31:0] ADDR_DATA = 32'h5300_0000,
    parameter logic [31:0] ADDR_DIR  = 32'h5300_0004,
    parameter int          TIMEOUT   = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [1:0]  req_sel,
    input  logic [31:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        cfg_parity_sel,
    ahb_gpio_master_arb_if.master bus
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        grant_q;
    logic        last_q;
    logic        wr_q;
    logic        sel_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        err_q;
    logic [7:0]  cnt_q;
    logic        psel_q;

    logic        g;
    logic        accept;
    logic        done;
    logic        tout;
    logic        unused_hi;

    assign unused_hi = ^bus.HRDATA[31:16];

    // Alternate only on a tie; a lone requester always wins.
    assign g = (req_valid == 2'b11) ? ~last_q : req_valid[1];

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        tout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    accept  = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: state_d = DATA;
            DATA: begin
                if (bus.HREADYOUT) begin
                    done    = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    tout    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset gates the accept strobe so nothing is offered while the bus is held.
    assign req_ready     = (accept && HRESETn) ? (g ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid     = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata     = (state_q == RESP) ? rdata_q : 16'h0;
    assign rsp_err       = (state_q == RESP) && err_q;

    assign bus.HSEL      = (state_q == ADDR);
    assign bus.HTRANS    = (state_q == ADDR) ? 2'b10 : 2'b00;
    assign bus.HADDR     = (state_q == ADDR) ? (sel_q ? ADDR_DIR : ADDR_DATA) : 32'h0;
    assign bus.HWRITE    = (state_q == ADDR) && wr_q;
    assign bus.HWDATA    = ((state_q == DATA) && wr_q) ? {16'h0, wdata_q} : 32'h0;
    assign bus.HREADY    = bus.HREADYOUT;
    assign bus.PARITYSEL = psel_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            sel_q   <= 1'b0;
            wdata_q <= 16'h0;
            rdata_q <= 16'h0;
            err_q   <= 1'b0;
            cnt_q   <= 8'h0;
            psel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            psel_q  <= cfg_parity_sel;
            if (accept) begin
                grant_q <= g;
                last_q  <= g;
                wr_q    <= req_write[g];
                sel_q   <= req_sel[g];
                wdata_q <= g ? req_wdata[31:16] : req_wdata[15:0];
                cnt_q   <= 8'h0;
            end
            if (done) begin
                rdata_q <= wr_q ? 16'h0 : bus.HRDATA[15:0];
                err_q   <= bus.PARITYERR & ~wr_q;
            end else if (tout) begin
                rdata_q <= 16'h0;
                err_q   <= 1'b1;
            end else if (state_q == DATA) begin
                cnt_q <= cnt_q + 8'h1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_gpio_master_arb.sv
// Bench for ahb_gpio_master_arb: directed scenarios plus randomized transfers.
// Every result is checked against a transaction-level model of the arbiter.
module tb_ahb_gpio_master_arb;

    localparam int TIMEOUT = 16;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [1:0]  req_sel = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        cfg_parity_sel = 1'b0;

    ahb_gpio_master_arb_if bus ();

    ahb_gpio_master_arb #(
        .ADDR_DATA(32'h5300_0000), .ADDR_DIR(32'h5300_0004), .TIMEOUT(TIMEOUT)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_sel(req_sel),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cfg_parity_sel(cfg_parity_sel), .bus(bus)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_err = 0;

    // Model: pending request per requester plus the previous winner.
    bit          pend_v [2];
    bit          pend_w [2];
    bit          pend_s [2];
    logic [15:0] pend_d [2];
    int          last_g;
    logic        prev_cfg = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step_begin();
        @(negedge HCLK);
        cfg_parity_sel = 1'($urandom_range(0, 1));
    endtask

    task automatic settle();
        #1;
        check("parity_sel", {31'h0, bus.PARITYSEL}, {31'h0, prev_cfg});
        prev_cfg = cfg_parity_sel;
    endtask

    task automatic drive_reqs();
        req_valid = {pend_v[1], pend_v[0]};
        req_write = {pend_w[1], pend_w[0]};
        req_sel   = {pend_s[1], pend_s[0]};
        req_wdata = {pend_d[1], pend_d[0]};
    endtask

    task automatic set_req(input int r, input bit wr, input bit sel, input logic [15:0] d);
        pend_v[r] = 1'b1;
        pend_w[r] = wr;
        pend_s[r] = sel;
        pend_d[r] = d;
    endtask

    // One complete transfer; w = slave wait states, rd/perr = slave reply on completion.
    task automatic xact(input int w, input logic [31:0] rd, input bit perr);
        int          g;
        int          ndata;
        bit          wr, tout, hro;
        logic [31:0] addr;
        logic [15:0] wd;
        logic [1:0]  onehot;

        step_begin();
        drive_reqs();
        bus.HREADYOUT = 1'b1;
        settle();
        if (pend_v[0] && pend_v[1]) g = 1 - last_g;
        else                        g = pend_v[1] ? 1 : 0;
        onehot = (g == 1) ? 2'b10 : 2'b01;
        check("req_ready", {30'h0, req_ready}, {30'h0, onehot});
        check("idle_rsp_valid", {30'h0, rsp_valid}, 32'h0);
        wr   = pend_w[g];
        addr = pend_s[g] ? 32'h5300_0004 : 32'h5300_0000;
        wd   = pend_d[g];
        pend_v[g] = 1'b0;
        last_g = g;
        tout  = (w >= TIMEOUT);
        ndata = tout ? TIMEOUT : w + 1;

        step_begin();
        drive_reqs();
        bus.HREADYOUT = 1'($urandom_range(0, 1));
        settle();
        check("addr_hsel", {31'h0, bus.HSEL}, 32'h1);
        check("addr_htrans", {30'h0, bus.HTRANS}, 32'h2);
        check("addr_haddr", bus.HADDR, addr);
        check("addr_hwrite", {31'h0, bus.HWRITE}, {31'h0, wr});
        check("addr_req_ready", {30'h0, req_ready}, 32'h0);

        for (int k = 0; k < ndata; k++) begin
            step_begin();
            hro = (k >= w);
            bus.HREADYOUT = hro;
            bus.HRDATA    = (k == w) ? rd : $urandom;
            bus.PARITYERR = (k == w) ? perr : 1'($urandom_range(0, 1));
            settle();
            check("data_hsel", {31'h0, bus.HSEL}, 32'h0);
            check("data_htrans", {30'h0, bus.HTRANS}, 32'h0);
            check("data_hwdata", bus.HWDATA, wr ? {16'h0, wd} : 32'h0);
            check("hready", {31'h0, bus.HREADY}, {31'h0, hro});
            check("data_rsp_valid", {30'h0, rsp_valid}, 32'h0);
        end

        step_begin();
        bus.HREADYOUT = tout ? 1'b0 : 1'b1;
        bus.HRDATA    = $urandom;
        bus.PARITYERR = 1'($urandom_range(0, 1));
        settle();
        check("rsp_valid", {30'h0, rsp_valid}, {30'h0, onehot});
        check("rsp_rdata", {16'h0, rsp_rdata}, (tout || wr) ? 32'h0 : {16'h0, rd[15:0]});
        check("rsp_err", {31'h0, rsp_err}, {31'h0, tout | (perr & ~wr)});
        check("rsp_hsel", {31'h0, bus.HSEL}, 32'h0);
    endtask

    task automatic check_reset_outputs();
        check("rst_hsel", {31'h0, bus.HSEL}, 32'h0);
        check("rst_htrans", {30'h0, bus.HTRANS}, 32'h0);
        check("rst_haddr", bus.HADDR, 32'h0);
        check("rst_hwrite", {31'h0, bus.HWRITE}, 32'h0);
        check("rst_hwdata", bus.HWDATA, 32'h0);
        check("rst_parity_sel", {31'h0, bus.PARITYSEL}, 32'h0);
        check("rst_req_ready", {30'h0, req_ready}, 32'h0);
        check("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", {16'h0, rsp_rdata}, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    endtask

    initial begin
        bus.HREADYOUT = 1'b1;
        bus.HRDATA    = '0;
        bus.PARITYERR = 1'b0;
        for (int r = 0; r < 2; r++) begin
            pend_v[r] = 1'b0; pend_w[r] = 1'b0; pend_s[r] = 1'b0; pend_d[r] = '0;
        end
        last_g = 1;

        req_valid = 2'b11;
        repeat (3) @(negedge HCLK);
        check_reset_outputs();
        req_valid = 2'b00;
        HRESETn = 1'b1;

        // Write from requester 0, no wait states.
        set_req(0, 1'b1, 1'b0, 16'hA5A5);
        xact(0, 32'h0, 1'b0);
        // Read from requester 1, direction register, three wait states.
        set_req(1, 1'b0, 1'b1, 16'h0);
        xact(3, 32'h0001_1234, 1'b0);
        // Both valid continuously: strict alternation.
        set_req(0, 1'b1, 1'b0, 16'h1111);
        set_req(1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            xact(0, $urandom, 1'b0);
            if (!pend_v[0]) set_req(0, 1'b1, 1'b1, 16'($urandom));
            if (!pend_v[1]) set_req(1, 1'b0, 1'b1, 16'h0);
        end
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        // Parity error on read is reported, on write it is not.
        set_req(0, 1'b0, 1'b0, 16'h0);
        xact(1, 32'hFFFF_BEEF, 1'b1);
        set_req(1, 1'b1, 1'b0, 16'h5A5A);
        xact(2, 32'h0000_0000, 1'b1);
        // Slave never ready: timeout, then a normal transfer.
        set_req(0, 1'b0, 1'b1, 16'h0);
        xact(TIMEOUT + 4, 32'h0000_CAFE, 1'b0);
        set_req(1, 1'b0, 1'b0, 16'h0);
        xact(TIMEOUT - 1, 32'h0000_7777, 1'b0);
        set_req(0, 1'b0, 1'b0, 16'h0);
        xact(TIMEOUT, 32'h0000_8888, 1'b0);

        // Reset during the data phase drops the transfer.
        set_req(0, 1'b1, 1'b0, 16'h0F0F);
        set_req(1, 1'b0, 1'b1, 16'h0);
        step_begin(); drive_reqs(); bus.HREADYOUT = 1'b1; settle();
        step_begin(); settle();
        step_begin(); bus.HREADYOUT = 1'b0; settle();
        #1 HRESETn = 1'b0;
        #1 check_reset_outputs();
        @(negedge HCLK);
        check_reset_outputs();
        req_valid = 2'b00;
        HRESETn = 1'b1;
        prev_cfg = cfg_parity_sel;
        last_g = 1;
        set_req(0, 1'b1, 1'b0, 16'h0F0F);
        set_req(1, 1'b0, 1'b1, 16'h0);
        xact(0, 32'h0, 1'b0);
        xact(1, 32'h0000_4321, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            int w;
            for (int r = 0; r < 2; r++)
                if (!pend_v[r] && ($urandom_range(0, 9) < 6))
                    set_req(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            if (!pend_v[0] && !pend_v[1])
                set_req($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 16'($urandom));
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                            : $urandom_range(0, 4);
            xact(w, $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
